// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port RAM between instruction fetch and load/store, with a
// starvation guard for fetch and a bounded RAM handshake that aborts into a sticky bus error.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MAX_WAIT     = 15
) (
  input  logic              clock,
  input  logic              reset,
  // Instruction fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  // Load/store port
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  // RAM side
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack,
  // Hazard / status
  output logic              if_stall,
  output logic              mem_stall,
  output logic              bus_err
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);
  localparam logic [WW-1:0] WaitMax   = WW'(MAX_WAIT);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StBusyIf  = 2'd1;
  localparam logic [1:0] StBusyMem = 2'd2;
  localparam logic [1:0] StResp    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              ram_req_q, ram_req_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              mem_ready_q, mem_ready_d;
  logic              bus_err_q, bus_err_d;
  logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
  logic [WW-1:0]     wait_cnt_q, wait_cnt_d;

  logic starve_full;
  logic grant_if;
  logic grant_mem;
  logic busy;
  logic timeout;

  assign starve_full = (starve_cnt_q == StarveMax);
  // MEM has priority unless fetch has already been passed over STARVE_LIMIT times in a row.
  assign grant_if    = (state_q == StIdle) && if_req && (!mem_req || starve_full);
  assign grant_mem   = (state_q == StIdle) && mem_req && !grant_if;
  assign busy        = (state_q == StBusyIf) || (state_q == StBusyMem);
  assign timeout     = busy && !ram_ack && (wait_cnt_q == WaitMax);

  always_comb begin
    state_d      = state_q;
    ram_req_d    = ram_req_q;
    ram_we_d     = ram_we_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    if_rdata_d   = if_rdata_q;
    if_ready_d   = if_ready_q;
    mem_rdata_d  = mem_rdata_q;
    mem_ready_d  = mem_ready_q;
    bus_err_d    = bus_err_q;
    starve_cnt_d = starve_cnt_q;
    wait_cnt_d   = wait_cnt_q;

    case (state_q)
      StIdle: begin
        if (grant_mem) begin
          state_d     = StBusyMem;
          ram_req_d   = 1'b1;
          ram_we_d    = mem_we;
          ram_addr_d  = mem_addr;
          ram_wdata_d = mem_wdata;
          wait_cnt_d  = '0;
          if (!if_req) begin
            starve_cnt_d = '0;
          end else if (!starve_full) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
          end
        end else if (grant_if) begin
          state_d      = StBusyIf;
          ram_req_d    = 1'b1;
          ram_we_d     = 1'b0;
          ram_addr_d   = if_addr;
          ram_wdata_d  = '0;
          wait_cnt_d   = '0;
          starve_cnt_d = '0;
        end
      end

      StBusyIf, StBusyMem: begin
        if (ram_ack || timeout) begin
          state_d    = StResp;
          ram_req_d  = 1'b0;
          wait_cnt_d = '0;
          if (timeout) begin
            bus_err_d = 1'b1;
          end
          // An aborted access returns zero rather than whatever is on ram_rdata.
          if (state_q == StBusyIf) begin
            if_ready_d = 1'b1;
            if_rdata_d = ram_ack ? ram_rdata : '0;
          end else begin
            mem_ready_d = 1'b1;
            mem_rdata_d = ram_ack ? ram_rdata : '0;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + WW'(1);
        end
      end

      StResp: begin
        // Single response cycle keeps a still-held request from being granted twice.
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        state_d     = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      ram_req_q    <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      if_rdata_q   <= '0;
      if_ready_q   <= 1'b0;
      mem_rdata_q  <= '0;
      mem_ready_q  <= 1'b0;
      bus_err_q    <= 1'b0;
      starve_cnt_q <= '0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      ram_req_q    <= ram_req_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      if_rdata_q   <= if_rdata_d;
      if_ready_q   <= if_ready_d;
      mem_rdata_q  <= mem_rdata_d;
      mem_ready_q  <= mem_ready_d;
      bus_err_q    <= bus_err_d;
      starve_cnt_q <= starve_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign ram_req   = ram_req_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_ready = mem_ready_q;
  assign bus_err   = bus_err_q;

  assign if_stall  = if_req & ~if_ready_q;
  assign mem_stall = mem_req & ~mem_ready_q;

endmodule
